// File: rtl/video_data_compressor_if.sv
// Avalon-ST pixel sink plus frame-buffer write port of the video data compressor.
// slave = compressor side, master = the source/frame-buffer side that drives it.
interface video_data_compressor_if #(
    parameter int ErrCountBits = 8
);
    logic [29:0]             data;
    logic                    startofpacket;
    logic                    endofpacket;
    logic                    valid;
    logic                    ready;
    logic                    wr_en;
    logic [18:0]             wr_addr;
    logic [11:0]             wr_data;
    logic                    wr_ready;
    logic                    frame_done;
    logic                    frame_error;
    logic [ErrCountBits-1:0] error_count;

    modport slave (
        input  data, startofpacket, endofpacket, valid, wr_ready,
        output ready, wr_en, wr_addr, wr_data, frame_done, frame_error, error_count
    );

    modport master (
        output data, startofpacket, endofpacket, valid, wr_ready,
        input  ready, wr_en, wr_addr, wr_data, frame_done, frame_error, error_count
    );
endinterface

// File: rtl/video_data_compressor.sv
// Compresses 30-bit RGB Avalon-ST frames to RGB444 frame-buffer writes and checks framing.
// Define VIDEO_COMPRESSOR_ROUND_EN for round-half-up with saturation instead of truncation.
module video_data_compressor #(
    parameter int NumPixels    = 320 * 240,
    parameter int ErrCountBits = 8
) (
    input logic                    clk,
    input logic                    reset,
    video_data_compressor_if.slave bus_io
);

    typedef enum logic [1:0] {
        HUNT,
        RECV,
        DRAIN
    } state_e;

    localparam logic [18:0]             LastIdx = 19'(NumPixels - 1);
    localparam logic [ErrCountBits-1:0] ErrMax  = '1;

    function automatic logic [3:0] compressChannel(input logic [7:0] c8);
`ifdef VIDEO_COMPRESSOR_ROUND_EN
        if (c8 >= 8'hF8) begin
            return 4'hF;
        end
        return 4'((c8 + 8'd8) >> 4);
`else
        return 4'(c8 >> 4);
`endif
    endfunction

    state_e                  state_q, state_d;
    logic [18:0]             index_q, index_d;
    logic                    wrEn_q, wrEn_d;
    logic [18:0]             wrAddr_q, wrAddr_d;
    logic [11:0]             wrData_q, wrData_d;
    logic                    frameDone_q, frameDone_d;
    logic                    frameError_q, frameError_d;
    logic [ErrCountBits-1:0] errCount_q, errCount_d;

    logic        ready;
    logic        accept;
    logic        doWrite;
    logic [18:0] writeAddr;
    logic        frameDone;
    logic        frameErr;
    logic [11:0] pixel444;

    // The output register may only be reloaded once its held write has drained.
    assign ready  = !reset && (!wrEn_q || bus_io.wr_ready);
    assign accept = bus_io.valid && ready;

    assign pixel444 = {compressChannel(bus_io.data[29:22]),
                       compressChannel(bus_io.data[19:12]),
                       compressChannel(bus_io.data[9:2])};

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        doWrite   = 1'b0;
        writeAddr = index_q;
        frameDone = 1'b0;
        frameErr  = 1'b0;

        if (accept) begin
            if (bus_io.startofpacket) begin
                // A sop always opens a new frame; any frame still open is abandoned.
                if (state_q != HUNT) begin
                    frameErr = 1'b1;
                end
                doWrite   = 1'b1;
                writeAddr = '0;
                if (bus_io.endofpacket) begin
                    state_d = HUNT;
                    index_d = '0;
                    if (NumPixels == 1) begin
                        frameDone = 1'b1;
                    end else begin
                        frameErr = 1'b1;
                    end
                end else if (NumPixels == 1) begin
                    state_d = DRAIN;
                    index_d = '0;
                end else begin
                    state_d = RECV;
                    index_d = 19'd1;
                end
            end else begin
                case (state_q)
                    RECV: begin
                        doWrite = 1'b1;
                        if (bus_io.endofpacket) begin
                            state_d = HUNT;
                            index_d = '0;
                            if (index_q == LastIdx) begin
                                frameDone = 1'b1;
                            end else begin
                                frameErr = 1'b1;
                            end
                        end else if (index_q == LastIdx) begin
                            state_d = DRAIN;
                        end else begin
                            index_d = index_q + 19'd1;
                        end
                    end
                    DRAIN: begin
                        if (bus_io.endofpacket) begin
                            frameErr = 1'b1;
                            state_d  = HUNT;
                            index_d  = '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        wrEn_d   = wrEn_q && !bus_io.wr_ready;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        if (doWrite) begin
            wrEn_d   = 1'b1;
            wrAddr_d = writeAddr;
            wrData_d = pixel444;
        end
        frameDone_d  = frameDone;
        frameError_d = frameErr;
        errCount_d   = errCount_q;
        if (frameErr && errCount_q != ErrMax) begin
            errCount_d = errCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            index_q      <= '0;
            wrEn_q       <= 1'b0;
            wrAddr_q     <= '0;
            wrData_q     <= '0;
            frameDone_q  <= 1'b0;
            frameError_q <= 1'b0;
            errCount_q   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            wrEn_q       <= wrEn_d;
            wrAddr_q     <= wrAddr_d;
            wrData_q     <= wrData_d;
            frameDone_q  <= frameDone_d;
            frameError_q <= frameError_d;
            errCount_q   <= errCount_d;
        end
    end

    assign bus_io.ready       = ready;
    assign bus_io.wr_en       = wrEn_q;
    assign bus_io.wr_addr     = wrAddr_q;
    assign bus_io.wr_data     = wrData_q;
    assign bus_io.frame_done  = frameDone_q;
    assign bus_io.frame_error = frameError_q;
    assign bus_io.error_count = errCount_q;

endmodule

// File: doc/video_data_compressor.md
# video_data_compressor

Avalon-ST video sink that receives 30-bit RGB pixel packets (8 colour bits plus 2 padding bits per channel, framed by startofpacket/endofpacket) and compresses each beat to 12-bit RGB444. Pixels are written into a frame-buffer BRAM through a registered write port with backpressure. It is the receive-side counterpart of the 12-to-30-bit expander and sits between the VFX pipeline output and the 320x240 frame store. It also checks framing and reports completed and malformed frames.

## Interface
- NumPixels, 320*240: pixels per frame; valid addresses are 0..NumPixels-1.
- ErrCountBits, 8: width of the saturating error counter.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data  in  30  pixel; R=data[29:22], G=data[19:12], B=data[9:2]; padding bits ignored
- startofpacket  in  1  first beat of frame
- endofpacket  in  1  last beat of frame
- valid  in  1  upstream beat valid
- ready  out  1  sink can accept a beat
- wr_en  out  1  write strobe to frame buffer
- wr_addr  out  19  pixel address
- wr_data  out  12  {R4,G4,B4}
- wr_ready  in  1  frame buffer accepts the write
- frame_done  out  1  one-cycle pulse: well-formed frame fully written
- frame_error  out  1  one-cycle pulse: malformed frame detected
- error_count  out  ErrCountBits  saturating count of frame_error pulses

## Operation
- Beat accepted when valid && ready. ready = !reset && (!wr_en || wr_ready).
- Output register: an accepted beat that is to be written loads wr_en=1, wr_addr, wr_data next cycle. Held stable until wr_ready=1. A new accepted beat may reload the register in the same cycle the held write drains.
- Compression (default): truncate, R4=R8[7:4], etc.
- States:
  - HUNT: reset state. Beats without sop are discarded (accepted, no write). A sop beat is written at addr 0, index:=1, then → RECV. If the same beat also has eop and NumPixels>1: short frame, frame_error, stay in HUNT.
  - RECV: each beat is written at the current index, then index++.
    - sop mid-frame: frame_error. The beat is written at addr 0, index:=1, stay in RECV.
    - eop with index==NumPixels-1: frame_done, → HUNT.
    - eop with index<NumPixels-1: frame_error (short), → HUNT.
    - Non-eop beat at index==NumPixels-1: written, → DRAIN.
  - DRAIN: beats are discarded. On eop: frame_error (long), → HUNT. On sop: frame_error, restart as in HUNT sop handling, → RECV.
- sop has priority over eop when both arrive in RECV/DRAIN: error on the old frame, then the beat is treated as in HUNT.
- error_count increments on every frame_error and saturates at all-ones.
- reset mid-frame: all state is dropped, the pending write is discarded (wr_en=0), → HUNT.

## Timing
- Reset values: ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_error=0, error_count=0, state=HUNT, index=0.
- Latency: accepted beat → wr_en high on the next clock edge (1 cycle).
- frame_done and frame_error are registered and asserted the cycle after the triggering beat is accepted. frame_done coincides with the first cycle of wr_en for the last pixel.
- Sustained throughput is 1 pixel/cycle when wr_ready=1 and valid=1.
- With wr_ready=0 and wr_en=1, ready=0 the same cycle (combinational), so no beat is lost.
- Pixel index is 19 bits and never exceeds NumPixels-1. It never wraps silently.

## Configuration
- VIDEO_COMPRESSOR_ROUND_EN defined: each channel uses round-half-up with saturation, c4 = min(15, (c8+8)>>4). For example, 0xF8 → 15 and 0x17 → 1.
- Undefined: truncation, c4 = c8[7:4]. For example, 0x17 → 1 and 0x18 → 1.

## Test plan
- Reset, then a 4-pixel frame (NumPixels=4) with data 0x3FF00000, 0x000FFC00, 0x000003FF, 0x00000000 and wr_ready=1 → writes addr 0..3 with 0xF00, 0x0F0, 0x00F, 0x000; frame_done pulses once with addr 3; error_count=0.
- Three beats without sop, then a valid frame → no writes for the first three beats; frame written at addr 0..3.
- eop on the 2nd beat (NumPixels=4) → writes addr 0,1; frame_error pulses; error_count=1; the next sop writes addr 0.
- 6-beat frame (NumPixels=4) → writes addr 0..3 only; beats 5 and 6 discarded; frame_error at eop; no frame_done.
- wr_ready held 0 for 3 cycles mid-frame → ready low during the stall; wr_en, wr_addr and wr_data held stable; no pixel lost or duplicated.
- With VIDEO_COMPRESSOR_ROUND_EN, R8=0xF8 and G8=0x17 → wr_data[11:8]=0xF and wr_data[7:4]=0x1. Without it, the same input gives 0xF and 0x1, while R8=0x18 gives 0x1 (rounded build gives 0x2).
